// File: rtl/hc_pkg.sv
// hc_pkg: shared types for the host-side CCI-P models.
//   - A reduced CCI-P type set: request headers for c0 (read) and c1 (write),
//     response headers, and the Tx/Rx interface structs.
//   - Responder defaults (HC_RSP_*) and the read-queue entry type.
//   - Request/response handshake: valid-only. A request exists in every cycle
//     its valid bit is 1 and is never stalled. c0TxAlmFull is advisory flow
//     control the requestor is expected to honour. rspValid marks one
//     response per cycle per channel.
package hc_pkg;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    logic [3:0]   req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    logic [3:0]   req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  localparam int HC_RSP_MEM_LINES     = 1024;
  localparam int HC_RSP_RD_DEPTH      = 32;
  localparam int HC_RSP_RD_LATENCY    = 16;
  localparam int HC_RSP_WR_LATENCY    = 8;
  localparam int HC_RSP_ALMFULL_SLACK = 8;

  // Line index is stored at a fixed 16 bits so the entry type does not depend
  // on the memory size; the responder uses only the low $clog2(MEM_LINES) bits.
  typedef struct packed {
    logic [15:0] line;
    t_ccip_mdata mdata;
    logic [15:0] stamp;
  } t_rsp_rd_entry;

endpackage

// File: rtl/hc_fifo.sv
// hc_fifo: show-ahead synchronous FIFO.
//   clk, reset_n          clock, asynchronous active-low reset
//   push, push_data       write strobe and data; ignored when full unless
//                         pop is taken in the same cycle
//   pop                   consume head entry; ignored when empty
//   pop_data              head entry, valid whenever empty is 0
//   empty, full, count    registered occupancy status
module hc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/hc_ccip_responder.sv
// hc_ccip_responder: host-side CCI-P memory responder.
//   clk, reset_n   clock, asynchronous active-low reset
//   ccip_c0_tx     read requests (address, mdata, cl_len, valid)
//   ccip_c1_tx     write requests (address, mdata, cl_len, data, valid)
//   ccip_rx        c0 read / c1 write responses and almost-full flags
//   rd_pending     reads queued but not yet answered
//   error          sticky: read dropped on a full queue, or cl_len != 1 line
// Writes commit to the line memory in the accept cycle and are acknowledged
// exactly WR_LATENCY cycles later. Reads are queued with a timestamp and
// answered in order once they have aged RD_LATENCY cycles, one per cycle.
// Requests are valid-only (never stalled); c0TxAlmFull is the only flow
// control and a read arriving on a full queue is dropped.
module hc_ccip_responder
  import hc_pkg::*;
#(
  parameter int MEM_LINES     = HC_RSP_MEM_LINES,
  parameter int RD_DEPTH      = HC_RSP_RD_DEPTH,
  parameter int RD_LATENCY    = HC_RSP_RD_LATENCY,
  parameter int WR_LATENCY    = HC_RSP_WR_LATENCY,
  parameter int ALMFULL_SLACK = HC_RSP_ALMFULL_SLACK
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  t_if_ccip_c0_Tx            ccip_c0_tx,
  input  t_if_ccip_c1_Tx            ccip_c1_tx,
  output t_if_ccip_Rx               ccip_rx,
  output logic [$clog2(RD_DEPTH):0] rd_pending,
  output logic                      error
);
  localparam int              LW        = $clog2(MEM_LINES);
  localparam int              CW        = $clog2(RD_DEPTH) + 1;
  localparam int              EW        = $bits(t_rsp_rd_entry);
  localparam logic [15:0]     RD_LAT    = 16'(RD_LATENCY);
  localparam logic [CW-1:0]   ALM_LEVEL = CW'(RD_DEPTH - ALMFULL_SLACK);

  t_ccip_clData    mem [MEM_LINES];
  logic [15:0]     stamp;
  t_rsp_rd_entry   enq_entry;
  t_rsp_rd_entry   head;
  logic [EW-1:0]   head_bits;
  logic            q_empty;
  logic            q_full;
  logic            enq;
  logic            deq;
  logic            drop;
  logic            len_err;
  logic            bypass;
  logic            alm_full;
  logic [15:0]     head_age;
  logic [CW-1:0]   occ_next;
  logic [LW-1:0]   wr_line;
  logic [LW-1:0]   rd_line;
  t_ccip_clData    rd_line_data;

  logic [WR_LATENCY-1:0] wr_vld;
  t_ccip_mdata           wr_md [WR_LATENCY];

  logic            rd_rsp_vld;
  t_ccip_mdata     rd_rsp_md;
  t_ccip_clData    rd_rsp_data;

  // Header fields outside the ones modelled here are accepted and ignored.
  logic unused_ok;
  assign unused_ok = ^{ccip_c0_tx, ccip_c1_tx, head_bits};

  always_comb begin
    enq_entry       = '0;
    enq_entry.line  = 16'(ccip_c0_tx.hdr.address[LW-1:0]);
    enq_entry.mdata = ccip_c0_tx.hdr.mdata;
    enq_entry.stamp = stamp;
  end

  assign head     = head_bits;
  assign wr_line  = ccip_c1_tx.hdr.address[LW-1:0];
  assign rd_line  = head.line[LW-1:0];
  // Modular age keeps working across timestamp wrap.
  assign head_age = stamp - head.stamp;
  assign deq      = !q_empty && (head_age >= RD_LAT);
  assign enq      = ccip_c0_tx.valid && (!q_full || deq);
  assign drop     = ccip_c0_tx.valid && q_full && !deq;
  assign len_err  = (ccip_c0_tx.valid && (ccip_c0_tx.hdr.cl_len != eCL_LEN_1)) ||
                    (ccip_c1_tx.valid && (ccip_c1_tx.hdr.cl_len != eCL_LEN_1));

  // The memory write lands at the clock edge, so a same-cycle write to the
  // line being read must be forwarded for the read to see the new data.
  assign bypass       = ccip_c1_tx.valid && (wr_line == rd_line);
  assign rd_line_data = bypass ? ccip_c1_tx.data : mem[rd_line];

  always_comb begin
    occ_next = rd_pending;
    if (enq && !deq)      occ_next = rd_pending + CW'(1);
    else if (!enq && deq) occ_next = rd_pending - CW'(1);
  end

  hc_fifo #(
    .WIDTH (EW),
    .DEPTH (RD_DEPTH)
  ) u_rd_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (enq),
    .push_data (enq_entry),
    .pop       (deq),
    .pop_data  (head_bits),
    .empty     (q_empty),
    .full      (q_full),
    .count     (rd_pending)
  );

  // Backing memory is deliberately not reset: contents survive reset.
  always_ff @(posedge clk) begin
    if (ccip_c1_tx.valid) mem[wr_line] <= ccip_c1_tx.data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stamp       <= '0;
      alm_full    <= 1'b0;
      error       <= 1'b0;
      rd_rsp_vld  <= 1'b0;
      rd_rsp_md   <= '0;
      rd_rsp_data <= '0;
      wr_vld      <= '0;
      for (int i = 0; i < WR_LATENCY; i++) wr_md[i] <= '0;
    end else begin
      stamp       <= stamp + 16'd1;
      alm_full    <= (occ_next >= ALM_LEVEL);
      error       <= error | drop | len_err;
      rd_rsp_vld  <= deq;
      rd_rsp_md   <= deq ? head.mdata : '0;
      rd_rsp_data <= deq ? rd_line_data : '0;
      // Write-ack delay line: stage WR_LATENCY-1 drives the c1 response.
      for (int i = WR_LATENCY - 1; i > 0; i--) begin
        wr_vld[i] <= wr_vld[i-1];
        wr_md[i]  <= wr_md[i-1];
      end
      wr_vld[0] <= ccip_c1_tx.valid;
      wr_md[0]  <= ccip_c1_tx.valid ? ccip_c1_tx.hdr.mdata : '0;
    end
  end

  always_comb begin
    ccip_rx                    = '0;
    ccip_rx.c0TxAlmFull        = alm_full;
    ccip_rx.c1TxAlmFull        = 1'b0;
    ccip_rx.c0.rspValid        = rd_rsp_vld;
    ccip_rx.c0.hdr.resp_type   = eRSP_RDLINE;
    ccip_rx.c0.hdr.mdata       = rd_rsp_md;
    ccip_rx.c0.data            = rd_rsp_data;
    ccip_rx.c1.rspValid        = wr_vld[WR_LATENCY-1];
    ccip_rx.c1.hdr.resp_type   = eRSP_WRLINE;
    ccip_rx.c1.hdr.mdata       = wr_md[WR_LATENCY-1];
  end

endmodule

// File: tb/tb_hc_ccip_responder.sv
// tb_hc_ccip_responder: bench for hc_ccip_responder.
// u_dut uses default parameters; u_big uses a long read latency so the read
// queue can be filled before anything drains (almost-full and overflow).
module tb_hc_ccip_responder;
  import hc_pkg::*;

  localparam int DEPTH  = 32;
  localparam int RL     = 16;
  localparam int WL     = 8;
  localparam int SLACK  = 8;
  localparam int BIG_RL = 48;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic b_reset_n;

  t_if_ccip_c0_Tx c0_tx, b_c0_tx;
  t_if_ccip_c1_Tx c1_tx, b_c1_tx;
  t_if_ccip_Rx    rx, b_rx;
  logic [5:0]     rd_pending, b_rd_pending;
  logic           error, b_error;

  hc_ccip_responder #(
    .MEM_LINES(1024), .RD_DEPTH(DEPTH), .RD_LATENCY(RL),
    .WR_LATENCY(WL), .ALMFULL_SLACK(SLACK)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .ccip_c0_tx(c0_tx), .ccip_c1_tx(c1_tx),
    .ccip_rx(rx), .rd_pending(rd_pending), .error(error)
  );

  hc_ccip_responder #(
    .MEM_LINES(1024), .RD_DEPTH(DEPTH), .RD_LATENCY(BIG_RL),
    .WR_LATENCY(WL), .ALMFULL_SLACK(SLACK)
  ) u_big (
    .clk(clk), .reset_n(b_reset_n), .ccip_c0_tx(b_c0_tx), .ccip_c1_tx(b_c1_tx),
    .ccip_rx(b_rx), .rd_pending(b_rd_pending), .error(b_error)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference model: line memory, pending reads, and time-stamped expectations.
  logic [511:0] mem_m [1024];
  logic [63:0]  mdl_rq[$];      // {accept cycle, line, mdata}
  logic [559:0] exp_q[$];       // c0: {cycle, mdata, data}
  logic [47:0]  exp_wr_q[$];    // c1: {cycle, mdata}
  bit           err_m;

  task automatic check_outputs();
    logic [559:0] e;
    logic [47:0]  w;
    if (exp_q.size() > 0 && int'(exp_q[0][559:528]) == cyc) begin
      e = exp_q.pop_front();
      check("c0_valid", rx.c0.rspValid, 1);
      check("c0_mdata", rx.c0.hdr.mdata, e[527:512]);
      check("c0_data", rx.c0.data, e[511:0]);
      check("c0_type", rx.c0.hdr.resp_type, eRSP_RDLINE);
    end else begin
      check("c0_idle", rx.c0.rspValid, 0);
    end
    if (exp_wr_q.size() > 0 && int'(exp_wr_q[0][47:16]) == cyc) begin
      w = exp_wr_q.pop_front();
      check("c1_valid", rx.c1.rspValid, 1);
      check("c1_mdata", rx.c1.hdr.mdata, w[15:0]);
      check("c1_type", rx.c1.hdr.resp_type, eRSP_WRLINE);
    end else begin
      check("c1_idle", rx.c1.rspValid, 0);
    end
    check("rd_pending", rd_pending, mdl_rq.size());
    check("c0_almfull", rx.c0TxAlmFull, mdl_rq.size() >= DEPTH - SLACK);
    check("c1_almfull", rx.c1TxAlmFull, 0);
    check("error", error, err_m);
  endtask

  // ---------------- driver ----------------
  // Called at the start of a cycle (1ns after the rising edge).
  task automatic step(input bit rv, input logic [41:0] ra, input logic [15:0] rm,
                      input bit wv, input logic [41:0] wa, input logic [15:0] wm,
                      input logic [511:0] wd, input bit bad_len);
    t_ccip_clLen ln;
    logic [63:0] h;
    ln = bad_len ? eCL_LEN_2 : eCL_LEN_1;
    check_outputs();
    c0_tx = '0;
    c0_tx.valid = rv; c0_tx.hdr.address = ra; c0_tx.hdr.mdata = rm; c0_tx.hdr.cl_len = ln;
    c1_tx = '0;
    c1_tx.valid = wv; c1_tx.hdr.address = wa; c1_tx.hdr.mdata = wm; c1_tx.hdr.cl_len = ln;
    c1_tx.data = wd;
    // write commits this cycle, so a read leaving this cycle sees it
    if (wv) begin
      mem_m[wa[9:0]] = wd;
      exp_wr_q.push_back({32'(cyc + WL), wm});
      if (bad_len) err_m = 1'b1;
    end
    if (mdl_rq.size() > 0) begin
      h = mdl_rq[0];
      if (int'(h[63:32]) + RL <= cyc) begin
        void'(mdl_rq.pop_front());
        exp_q.push_back({32'(cyc + 1), h[15:0], mem_m[h[25:16]]});
      end
    end
    if (rv) begin
      if (bad_len) err_m = 1'b1;
      if (mdl_rq.size() == DEPTH) err_m = 1'b1;
      else mdl_rq.push_back({32'(cyc), 6'd0, ra[9:0], rm});
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, '0, 0);
  endtask

  task automatic rd(input logic [41:0] a, input logic [15:0] m, input bit bl);
    step(1, a, m, 0, '0, '0, '0, bl);
  endtask

  task automatic wr(input logic [41:0] a, input logic [15:0] m, input logic [511:0] d);
    step(0, '0, '0, 1, a, m, d, 0);
  endtask

  task automatic do_reset();
    c0_tx = '0; c1_tx = '0;
    reset_n = 1'b0;
    #1;
    check("rst_c0_valid", rx.c0.rspValid, 0);
    check("rst_c1_valid", rx.c1.rspValid, 0);
    check("rst_almfull", rx.c0TxAlmFull, 0);
    check("rst_pending", rd_pending, 0);
    check("rst_error", error, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cyc++;
    mdl_rq.delete(); exp_q.delete(); exp_wr_q.delete();
    err_m = 1'b0;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom();
    return d;
  endfunction

  // random line 0..63 with random upper address bits (exercise wrap)
  function automatic logic [41:0] rand_addr();
    logic [41:0] a;
    a = '0;
    a[5:0]   = 6'($urandom_range(0, 63));
    a[12:10] = 3'($urandom_range(0, 7));
    return a;
  endfunction

  task automatic random_phase(input int n, input bit allow_bad);
    bit rv, wv, bl;
    for (int i = 0; i < n; i++) begin
      rv = ($urandom_range(0, 99) < 60);
      wv = ($urandom_range(0, 99) < 40);
      bl = allow_bad && ($urandom_range(0, 19) == 0);
      step(rv, rand_addr(), 16'($urandom_range(0, 65535)),
           wv, rand_addr(), 16'($urandom_range(0, 65535)), rand_data(), bl);
    end
  endtask

  task automatic big_reset();
    b_c0_tx = '0; b_c1_tx = '0;
    b_reset_n = 1'b0;
    @(posedge clk); #1;
    b_reset_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  int exp_pend;
  int n_rsp;
  logic [511:0] pat;

  initial begin
    c0_tx = '0; c1_tx = '0; b_c0_tx = '0; b_c1_tx = '0;
    reset_n = 1'b0; b_reset_n = 1'b0; err_m = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1; b_reset_n = 1'b1;

    // preload lines used by reads
    for (int i = 0; i < 64; i++) wr(42'(i), 16'(i), rand_data());
    idle(12);

    // write line 5 = A5.., ack after 8 cycles; read back 17 cycles later
    pat = {64{8'hA5}};
    wr(42'd5, 16'd3, pat);
    idle(10);
    rd(42'd5, 16'd7, 0);
    idle(20);

    // address wrap: 1029 aliases line 5
    wr(42'd1029, 16'd11, rand_data());
    idle(2);
    rd(42'd5, 16'd12, 0);
    idle(20);

    // same-cycle bypass: write lands in the read's dequeue cycle
    wr(42'd9, 16'd20, 512'h11);
    idle(10);
    rd(42'd9, 16'd21, 0);
    idle(RL - 1);
    wr(42'd9, 16'd22, 512'h22);
    idle(20);

    random_phase(300, 0);
    idle(30);

    // reset with reads outstanding: nothing comes back afterwards
    for (int i = 0; i < 4; i++) rd(42'(i), 16'(100 + i), 0);
    idle(3);
    do_reset();
    idle(30);

    // bad cl_len: flagged, still served as one line
    rd(42'd3, 16'd50, 1);
    idle(20);
    random_phase(300, 1);
    idle(30);

    // almost-full on the long-latency instance: 24 back-to-back reads
    big_reset();
    for (int k = 0; k < 80; k++) begin
      if (k <= 24)      exp_pend = k;
      else if (k <= 48) exp_pend = 24;
      else              exp_pend = (k - 48 >= 24) ? 0 : 24 - (k - 48);
      check("bp_pending", b_rd_pending, exp_pend);
      check("bp_almfull", b_rx.c0TxAlmFull, exp_pend >= DEPTH - SLACK);
      if (k >= BIG_RL + 1 && k <= BIG_RL + 24) begin
        check("bp_valid", b_rx.c0.rspValid, 1);
        check("bp_mdata", b_rx.c0.hdr.mdata, k - (BIG_RL + 1));
      end else begin
        check("bp_idle", b_rx.c0.rspValid, 0);
      end
      b_c0_tx = '0;
      if (k < 24) begin
        b_c0_tx.valid = 1'b1;
        b_c0_tx.hdr.mdata = 16'(k);
        b_c0_tx.hdr.cl_len = eCL_LEN_1;
      end
      @(posedge clk); #1;
    end
    check("bp_error", b_error, 0);

    // overflow: 33 reads before any can drain
    big_reset();
    n_rsp = 0;
    for (int k = 0; k < 120; k++) begin
      check("ovf_error", b_error, k >= 33);
      if (b_rx.c0.rspValid) begin
        check("ovf_order", b_rx.c0.hdr.mdata, n_rsp);
        n_rsp++;
      end
      b_c0_tx = '0;
      if (k < 33) begin
        b_c0_tx.valid = 1'b1;
        b_c0_tx.hdr.mdata = 16'(k);
        b_c0_tx.hdr.cl_len = eCL_LEN_1;
      end
      @(posedge clk); #1;
    end
    check("ovf_count", n_rsp, 32);
    check("ovf_pending", b_rd_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
